// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul host controller and the engine side:
// bus address map, STATUS bit positions, op-register indices and FSM states.
package matmul_pkg;

  // Word-address map. Regions are selected by bus_addr[9:8].
  localparam logic [9:0] ADDR_OP_BASE = 10'h000;
  localparam logic [9:0] ADDR_GO      = 10'h005;
  localparam logic [9:0] ADDR_STATUS  = 10'h006;
  localparam logic [9:0] ADDR_COUNT   = 10'h007;
  localparam logic [9:0] ADDR_A_BASE  = 10'h100;
  localparam logic [9:0] ADDR_B_BASE  = 10'h200;
  localparam logic [9:0] ADDR_C_BASE  = 10'h300;

  // STATUS bit positions. Bit 0 is live, bits 1..4 are sticky and W1C.
  localparam int ST_BUSY        = 0;
  localparam int ST_DONE        = 1;
  localparam int ST_ERR_DIM     = 2;
  localparam int ST_ERR_BUSY    = 3;
  localparam int ST_ERR_TIMEOUT = 4;

  // Operation register indices as seen by the engine on mm_op.
  localparam int OP_CODE     = 0;
  localparam int OP_WIDTH_A  = 1;
  localparam int OP_HEIGHT_A = 2;
  localparam int OP_WIDTH_B  = 3;
  localparam int OP_HEIGHT_B = 4;
  localparam int OP_RUNNING  = 5;
  localparam int OP_STATUS   = 6;
  localparam int NUM_OP_RW   = 5;
  localparam int NUM_OP_REGS = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_RUN,
    S_CAPTURE,
    S_ABORT
  } mm_state_e;

  // A matrix dimension is legal when it is 1..dim.
  function automatic logic dim_ok(input logic [31:0] v, input int dim);
    return (v != 32'd0) && (v <= 32'(dim));
  endfunction

endpackage

// File: rtl/matmul_regbank.sv
// Bus-facing register bank: address decode, op/A/B storage, C result buffer,
// read mux and the one-cycle bus acknowledge. Writes to op/A/B/GO are dropped
// while the controller is busy and reported back as busy_wr_err.
module matmul_regbank
  import matmul_pkg::*;
#(
  parameter int DIM = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  bus_req,
  input  logic                                  bus_we,
  input  logic [9:0]                            bus_addr,
  input  logic [31:0]                           bus_wdata,
  output logic                                  bus_ack,
  output logic [31:0]                           bus_rdata,
  input  logic                                  busy,
  input  logic                                  capture,
  input  logic [DIM*DIM-1:0][31:0]              mm_c,
  input  logic [31:0]                           status_word,
  input  logic [31:0]                           run_count,
  output logic [NUM_OP_RW-1:0][31:0]            op_regs,
  output logic [DIM*DIM-1:0][31:0]              mm_a,
  output logic [DIM*DIM-1:0][31:0]              mm_b,
  output logic                                  go_wr,
  output logic [ST_ERR_TIMEOUT:ST_DONE]         status_clr,
  output logic                                  busy_wr_err
);

  localparam int NELEM = DIM * DIM;
  localparam int IW    = $clog2(NELEM);

  logic [DIM*DIM-1:0][31:0] c_buf;
  logic [1:0]               region;
  logic [7:0]               off;
  logic [IW-1:0]            idx;
  logic                     in_mat;
  logic                     sel_op, sel_go, sel_status, sel_count;
  logic                     sel_a, sel_b, sel_c;
  logic                     wr, rd;
  logic [31:0]              rdata_d;

  // Address decode and write-side strobes toward the controller.
  always_comb begin
    region      = bus_addr[9:8];
    off         = bus_addr[7:0];
    idx         = off[IW-1:0];
    in_mat      = int'(off) < NELEM;
    wr          = bus_req & bus_we;
    rd          = bus_req & ~bus_we;
    sel_op      = (region == ADDR_OP_BASE[9:8]) && (off <= 8'(OP_HEIGHT_B));
    sel_go      = (bus_addr == ADDR_GO);
    sel_status  = (bus_addr == ADDR_STATUS);
    sel_count   = (bus_addr == ADDR_COUNT);
    sel_a       = (region == ADDR_A_BASE[9:8]) && in_mat;
    sel_b       = (region == ADDR_B_BASE[9:8]) && in_mat;
    sel_c       = (region == ADDR_C_BASE[9:8]) && in_mat;
    go_wr       = wr & sel_go & bus_wdata[0] & ~busy;
    status_clr  = (wr & sel_status) ? bus_wdata[ST_ERR_TIMEOUT:ST_DONE] : '0;
    busy_wr_err = wr & busy & (sel_op | sel_a | sel_b | sel_go);
  end

  // Operand/op storage updates and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_regs <= '0;
      mm_a    <= '0;
      mm_b    <= '0;
      c_buf   <= '0;
    end else begin
      if (wr && !busy) begin
        if (sel_op) op_regs[off[2:0]] <= bus_wdata;
        if (sel_a)  mm_a[idx]         <= bus_wdata;
        if (sel_b)  mm_b[idx]         <= bus_wdata;
      end
      if (capture) c_buf <= mm_c;
    end
  end

  // Read mux; anything unmapped reads as zero.
  always_comb begin
    rdata_d = '0;
    if (sel_op)     rdata_d = op_regs[off[2:0]];
    if (sel_status) rdata_d = status_word;
    if (sel_count)  rdata_d = run_count;
    if (sel_a)      rdata_d = mm_a[idx];
    if (sel_b)      rdata_d = mm_b[idx];
    if (sel_c)      rdata_d = c_buf[idx];
  end

  // One-cycle acknowledge; read data only accompanies read acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= bus_req;
      bus_rdata <= rd ? rdata_d : '0;
    end
  end

endmodule

// File: rtl/matmul_host_ctrl.sv
// Host-side controller for the matrix-multiplication engine. Sequences engine
// reset/enable around a run, blanks the engine's stale done flag, enforces a
// run timeout and captures the result into the C buffer.
//
// state   | meaning
// IDLE    | waiting for GO; dimensions validated on GO
// KICK    | one-cycle engine reset pulse
// RUN     | engine enabled, cycles counted, done blanked for 2 cycles
// CAPTURE | copy result, latch count, set done, raise irq
// ABORT   | timeout: set err_timeout, one-cycle engine reset pulse
module matmul_host_ctrl
  import matmul_pkg::*;
#(
  parameter int DIM     = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bus_req,
  input  logic                         bus_we,
  input  logic [9:0]                   bus_addr,
  input  logic [31:0]                  bus_wdata,
  output logic                         bus_ack,
  output logic [31:0]                  bus_rdata,
  output logic                         irq,
  output logic                         mm_reset,
  output logic                         mm_enable,
  output logic [NUM_OP_REGS-1:0][31:0] mm_op,
  output logic [DIM*DIM-1:0][31:0]     mm_a,
  output logic [DIM*DIM-1:0][31:0]     mm_b,
  input  logic [DIM*DIM-1:0][31:0]     mm_c,
  input  logic                         mm_done
);

  mm_state_e                      state_q, state_d;
  logic [31:0]                    run_cnt;
  logic [31:0]                    count_q;
  logic [ST_ERR_TIMEOUT:ST_DONE]  sticky;
  logic [ST_ERR_TIMEOUT:ST_DONE]  status_clr;
  logic [ST_ERR_TIMEOUT:ST_DONE]  status_set;
  logic [ST_ERR_TIMEOUT:ST_DONE]  go_clr;
  logic [NUM_OP_RW-1:0][31:0]     op_regs;
  logic [31:0]                    status_word;
  logic                           busy, go_wr, busy_wr_err, dims_ok;
  logic                           pulse_rst, capture, go_ok, go_fail, set_timeout;

  matmul_regbank #(.DIM(DIM)) u_regbank (
    .clk         (clk),
    .reset       (reset),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .busy        (busy),
    .capture     (capture),
    .mm_c        (mm_c),
    .status_word (status_word),
    .run_count   (count_q),
    .op_regs     (op_regs),
    .mm_a        (mm_a),
    .mm_b        (mm_b),
    .go_wr       (go_wr),
    .status_clr  (status_clr),
    .busy_wr_err (busy_wr_err)
  );

  // Status word, dimension check and engine-facing op registers.
  always_comb begin
    busy        = (state_q != S_IDLE);
    status_word = '0;
    status_word[ST_BUSY] = busy;
    status_word[ST_ERR_TIMEOUT:ST_DONE] = sticky;
    dims_ok = dim_ok(op_regs[OP_WIDTH_A], DIM) && dim_ok(op_regs[OP_HEIGHT_A], DIM) &&
              dim_ok(op_regs[OP_WIDTH_B], DIM) && dim_ok(op_regs[OP_HEIGHT_B], DIM) &&
              (op_regs[OP_WIDTH_A] == op_regs[OP_HEIGHT_B]);
    mm_op = '0;
    mm_op[OP_HEIGHT_B:OP_CODE] = op_regs;
    mm_op[OP_RUNNING]          = {31'b0, state_q == S_RUN};
    mm_op[OP_STATUS]           = status_word;
    mm_reset = reset | pulse_rst;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state strobes. The engine reports done out of reset,
  // so done only qualifies once two RUN cycles have elapsed.
  always_comb begin
    state_d     = state_q;
    mm_enable   = 1'b0;
    pulse_rst   = 1'b0;
    capture     = 1'b0;
    go_ok       = 1'b0;
    go_fail     = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_wr) begin
          if (dims_ok) begin
            go_ok   = 1'b1;
            state_d = S_KICK;
          end else begin
            go_fail = 1'b1;
          end
        end
      end
      S_KICK: begin
        pulse_rst = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        mm_enable = 1'b1;
        if (mm_done && (run_cnt >= 32'd2))         state_d = S_CAPTURE;
        else if (run_cnt == 32'(TIMEOUT - 1))       state_d = S_ABORT;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        pulse_rst   = 1'b1;
        set_timeout = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RUN-cycle counter, latched run count and completion interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
      count_q <= '0;
      irq     <= 1'b0;
    end else begin
      if (state_q == S_KICK)      run_cnt <= '0;
      else if (state_q == S_RUN)  run_cnt <= run_cnt + 32'd1;
      if (capture) count_q <= run_cnt;
      irq <= capture;
    end
  end

  // Sticky status bits: W1C from the bus, a GO clears done/timeout, sets win.
  always_comb begin
    status_set = '0;
    status_set[ST_DONE]        = capture;
    status_set[ST_ERR_DIM]     = go_fail;
    status_set[ST_ERR_BUSY]    = busy_wr_err;
    status_set[ST_ERR_TIMEOUT] = set_timeout;
    go_clr = '0;
    go_clr[ST_DONE]        = go_ok;
    go_clr[ST_ERR_TIMEOUT] = go_ok;
  end

  // Sticky status register.
  always_ff @(posedge clk) begin
    if (reset) sticky <= '0;
    else       sticky <= (sticky & ~status_clr & ~go_clr) | status_set;
  end

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// Directed bench for matmul_host_ctrl with a simple engine model whose done
// behaviour is selectable: normal (done out of reset, then after 6 cycles),
// never done, or always done.
module tb_matmul_host_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic              bus_req, bus_we;
  logic [9:0]        bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic              irq, mm_reset, mm_enable, mm_done;
  logic [6:0][31:0]  mm_op;
  logic [15:0][31:0] mm_a, mm_b, mm_c;

  int checks = 0;
  int fails  = 0;
  int eng_mode = 0;
  int eng_cnt  = 0;
  int irq_cnt  = 0;
  int rst_cnt  = 0;
  int en_cnt   = 0;

  matmul_host_ctrl #(.DIM(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .irq       (irq),
    .mm_reset  (mm_reset),
    .mm_enable (mm_enable),
    .mm_op     (mm_op),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_c      (mm_c),
    .mm_done   (mm_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mm_c[i*4+j] = 32'd0;
        for (int k = 0; k < 4; k++)
          mm_c[i*4+j] = mm_c[i*4+j] + mm_a[i*4+k] * mm_b[k*4+j];
      end
  end

  assign mm_done = (eng_mode == 0) ? ((eng_cnt < 2) || (eng_cnt >= 6)) : (eng_mode == 2);

  always @(posedge clk) begin
    if (mm_reset)       eng_cnt <= 0;
    else if (mm_enable) eng_cnt <= eng_cnt + 1;
    if (irq) irq_cnt <= irq_cnt + 1;
    if (mm_reset && !reset) rst_cnt <= rst_cnt + 1;
    if (mm_enable) en_cnt <= en_cnt + 1;
  end

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a; bus_wdata = '0;
    @(posedge clk); #1;
    bus_req = 1'b0;
    d = bus_rdata;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (mm_op[6][0] === 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (mm_op[6][0] !== 1'b0) begin
      fails++; $display("FAIL wait_idle: busy still %0b after %0d cycles", mm_op[6][0], budget);
    end
  endtask

  task automatic load_basic();
    bus_write(10'h000, 0); bus_write(10'h001, 2); bus_write(10'h002, 2);
    bus_write(10'h003, 2); bus_write(10'h004, 2);
    bus_write(10'h100, 1); bus_write(10'h101, 2); bus_write(10'h104, 3); bus_write(10'h105, 4);
    bus_write(10'h200, 5); bus_write(10'h201, 6); bus_write(10'h204, 7); bus_write(10'h205, 8);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (mm_reset !== 1'b1) begin fails++; $display("FAIL rst_mm_reset: got %0b want 1", mm_reset); end
    checks++; if (bus_ack !== 1'b0 || irq !== 1'b0 || mm_enable !== 1'b0) begin
      fails++; $display("FAIL rst_outputs: ack=%0b irq=%0b en=%0b want 0", bus_ack, irq, mm_enable); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (mm_reset !== 1'b0) begin fails++; $display("FAIL rst_release: mm_reset=%0b want 0", mm_reset); end
    bus_read(10'h006, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rst_status: got %0h want 0", d); end
    bus_read(10'h001, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rst_op1: got %0h want 0", d); end
    bus_read(10'h300, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rst_c0: got %0h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int irq0, rst0, en0;
    eng_mode = 0;
    load_basic();
    bus_read(10'h001, d);
    checks++; if (d !== 32'd2) begin fails++; $display("FAIL op1_readback: got %0d want 2", d); end
    bus_read(10'h105, d);
    checks++; if (d !== 32'd4) begin fails++; $display("FAIL a11_readback: got %0d want 4", d); end
    irq0 = irq_cnt; rst0 = rst_cnt; en0 = en_cnt;
    bus_write(10'h005, 1);
    checks++; if (mm_reset !== 1'b1 || mm_enable !== 1'b0 || bus_rdata !== 32'h0) begin
      fails++; $display("FAIL kick_cycle: mm_reset=%0b en=%0b rdata=%0h want 1 0 0", mm_reset, mm_enable, bus_rdata); end
    @(posedge clk); #1;
    checks++; if (mm_enable !== 1'b1 || mm_op[5] !== 32'd1) begin
      fails++; $display("FAIL run_cycle: en=%0b op5=%0h want 1 1", mm_enable, mm_op[5]); end
    wait_idle(100);
    bus_read(10'h300, d);
    checks++; if (d !== 32'd19) begin fails++; $display("FAIL c00: got %0d want 19", d); end
    bus_read(10'h301, d);
    checks++; if (d !== 32'd22) begin fails++; $display("FAIL c01: got %0d want 22", d); end
    bus_read(10'h304, d);
    checks++; if (d !== 32'd43) begin fails++; $display("FAIL c10: got %0d want 43", d); end
    bus_read(10'h305, d);
    checks++; if (d !== 32'd50) begin fails++; $display("FAIL c11: got %0d want 50", d); end
    bus_read(10'h006, d);
    checks++; if (d !== 32'h02) begin fails++; $display("FAIL basic_status: got %0h want 2", d); end
    bus_read(10'h007, d);
    checks++; if (d !== 32'd7) begin fails++; $display("FAIL basic_count: got %0d want 7", d); end
    checks++; if (irq_cnt - irq0 != 1 || rst_cnt - rst0 != 1 || en_cnt - en0 != 7) begin
      fails++; $display("FAIL basic_pulses: irq=%0d rst=%0d en=%0d want 1 1 7", irq_cnt - irq0, rst_cnt - rst0, en_cnt - en0); end
    bus_read(10'h005, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL go_read: got %0h want 0", d); end
    bus_read(10'h110, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %0h want 0", d); end
  endtask

  task automatic test_dim_err();
    logic [31:0] d;
    int rst0;
    bus_write(10'h001, 5);
    rst0 = rst_cnt;
    bus_write(10'h005, 1);
    checks++; if (mm_reset !== 1'b0 || mm_op[6][0] !== 1'b0) begin
      fails++; $display("FAIL dim_no_kick: mm_reset=%0b busy=%0b want 0 0", mm_reset, mm_op[6][0]); end
    bus_read(10'h006, d);
    checks++; if (d !== 32'h06) begin fails++; $display("FAIL dim_status: got %0h want 6", d); end
    checks++; if (rst_cnt != rst0) begin fails++; $display("FAIL dim_rst_pulse: got %0d want %0d", rst_cnt, rst0); end
    bus_write(10'h006, 32'h06);
    bus_read(10'h006, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL w1c_clear: got %0h want 0", d); end
    bus_write(10'h001, 2);
  endtask

  task automatic test_busy_write();
    logic [31:0] d;
    eng_mode = 0;
    bus_write(10'h005, 1);
    bus_write(10'h100, 99);
    checks++; if (bus_ack !== 1'b1) begin fails++; $display("FAIL busy_ack: got %0b want 1", bus_ack); end
    bus_read(10'h100, d);
    checks++; if (d !== 32'd1) begin fails++; $display("FAIL busy_a00: got %0d want 1", d); end
    bus_read(10'h301, d);
    checks++; if (d !== 32'd22) begin fails++; $display("FAIL busy_c_old: got %0d want 22", d); end
    wait_idle(100);
    bus_read(10'h006, d);
    checks++; if (d !== 32'h0A) begin fails++; $display("FAIL busy_status: got %0h want a", d); end
    bus_write(10'h006, 32'h08);
    bus_read(10'h006, d);
    checks++; if (d !== 32'h02) begin fails++; $display("FAIL busy_clear: got %0h want 2", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int irq0, rst0, en0;
    eng_mode = 1;
    irq0 = irq_cnt; rst0 = rst_cnt; en0 = en_cnt;
    bus_write(10'h005, 1);
    wait_idle(100);
    @(posedge clk); #1;
    checks++; if (en_cnt - en0 != 16 || rst_cnt - rst0 != 2 || irq_cnt != irq0) begin
      fails++; $display("FAIL timeout_pulses: en=%0d rst=%0d irq=%0d want 16 2 0", en_cnt - en0, rst_cnt - rst0, irq_cnt - irq0); end
    bus_read(10'h006, d);
    checks++; if (d !== 32'h10) begin fails++; $display("FAIL timeout_status: got %0h want 10", d); end
    bus_read(10'h305, d);
    checks++; if (d !== 32'd50) begin fails++; $display("FAIL timeout_c_kept: got %0d want 50", d); end
    bus_read(10'h007, d);
    checks++; if (d !== 32'd7) begin fails++; $display("FAIL timeout_count: got %0d want 7", d); end
  endtask

  task automatic test_blank();
    logic [31:0] d;
    int en0;
    eng_mode = 2;
    en0 = en_cnt;
    bus_write(10'h005, 1);
    wait_idle(100);
    bus_read(10'h007, d);
    checks++; if (d !== 32'd3) begin fails++; $display("FAIL blank_count: got %0d want 3", d); end
    checks++; if (en_cnt - en0 != 3) begin fails++; $display("FAIL blank_en: got %0d want 3", en_cnt - en0); end
    bus_read(10'h006, d);
    checks++; if (d !== 32'h02) begin fails++; $display("FAIL blank_status: got %0h want 2", d); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    eng_mode = 1;
    bus_write(10'h005, 1);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (mm_enable !== 1'b1) begin fails++; $display("FAIL midrun_en: got %0b want 1", mm_enable); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (mm_enable !== 1'b0 || mm_reset !== 1'b1 || irq !== 1'b0 || bus_ack !== 1'b0) begin
      fails++; $display("FAIL midrun_outputs: en=%0b rst=%0b irq=%0b ack=%0b want 0 1 0 0", mm_enable, mm_reset, irq, bus_ack); end
    checks++; if (mm_op[6] !== 32'h0 || mm_op[1] !== 32'h0 || mm_a[0] !== 32'h0) begin
      fails++; $display("FAIL midrun_regs: status=%0h op1=%0h a0=%0h want 0", mm_op[6], mm_op[1], mm_a[0]); end
    reset = 1'b0;
    @(posedge clk); #1;
    bus_read(10'h300, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL midrun_c_cleared: got %0d want 0", d); end
    eng_mode = 0;
    load_basic();
    bus_write(10'h005, 1);
    wait_idle(100);
    bus_read(10'h305, d);
    checks++; if (d !== 32'd50) begin fails++; $display("FAIL rerun_c11: got %0d want 50", d); end
    bus_read(10'h006, d);
    checks++; if (d !== 32'h02) begin fails++; $display("FAIL rerun_status: got %0h want 2", d); end
    bus_read(10'h007, d);
    checks++; if (d !== 32'd7) begin fails++; $display("FAIL rerun_count: got %0d want 7", d); end
  endtask

  initial begin
    reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_dim_err();
    test_busy_write();
    test_timeout();
    test_blank();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/matmul_host_ctrl.md
# matmul_host_ctrl

Bus-side controller for the matrix-multiplication engine. It exposes a word-addressed register/memory map to the CPU and holds the operation registers and the A/B operand storage. It sequences the engine's reset/enable, watches its done flag, then captures the result matrix into a CPU-readable buffer. It is the initiator/host end of the engine's operation-register + matrix interface.

## Interface
Parameters:
- DIM, 4, matrix dimension: matrices are DIM×DIM, 32-bit elements.
- TIMEOUT, 4096, maximum RUN cycles before abort.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- bus_req  in  1  single-cycle request strobe.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  10  word address.
- bus_wdata  in  32  write data.
- bus_ack  out  1  one-cycle acknowledge, exactly 1 cycle after bus_req.
- bus_rdata  out  32  read data, valid with bus_ack; 0 on writes.
- irq  out  1  one-cycle pulse on successful completion.
- mm_reset  out  1  engine reset, equal to reset OR an internal pulse.
- mm_enable  out  1  engine enable.
- mm_op  out  7×32  operation registers 0..6 to the engine.
- mm_a, mm_b  out  DIM×DIM×32  operand matrices, driven directly from storage.
- mm_c  in  DIM×DIM×32  engine result.
- mm_done  in  1  engine done flag.

## Operation
Address map (word addresses):
- 0x000–0x004: op regs 0..4, R/W. Reg 0 is the op code; regs 1–4 are width A, height A, width B, height B.
- 0x005: GO, write-only. Writing bit0=1 requests a run. Reads return 0.
- 0x006: STATUS. bit0 busy, bit1 done, bit2 err_dim, bit3 err_busy, bit4 err_timeout. Bits 1–4 are sticky and write-1-to-clear.
- 0x007: last run cycle count, RO.
- 0x100 + i·DIM + j: A[i][j], R/W.
- 0x200 + i·DIM + j: B[i][j], R/W.
- 0x300 + i·DIM + j: C buffer, RO.
- Unmapped reads return 0. Unmapped writes are ignored.

mm_op[5] is driven 1 while in RUN, else 0. mm_op[6] mirrors STATUS.

FSM states:
- IDLE:
  - On a GO write, validate the dimensions: regs 1–4 each in 1..DIM, and reg1 == reg4.
  - Pass: clear done/err_timeout, go to KICK.
  - Fail: set err_dim, stay in IDLE.
- KICK: mm_reset=1 for exactly 1 cycle, then go to RUN.
- RUN:
  - mm_enable=1, cycle counter increments.
  - mm_done is ignored for the first 2 RUN cycles (the engine reports done=1 out of reset).
  - From the 3rd cycle on, mm_done=1 → CAPTURE.
  - Counter reaching TIMEOUT → ABORT.
- CAPTURE: copy mm_c into the C buffer, latch the cycle count, set done, pulse irq, drop mm_enable, return to IDLE.
- ABORT: set err_timeout, 1-cycle mm_reset pulse, return to IDLE. The C buffer is unchanged.

Busy rules:
- busy = state ≠ IDLE.
- While busy, writes to op regs, A, B, or GO are dropped, set err_busy, and are still acked.
- Reads while busy return current contents. C reads return the previous result.

## Timing
- Reset values:
  - bus_ack=0, bus_rdata=0, irq=0, mm_enable=0, mm_reset=1 (follows reset).
  - All op regs, A, B, C buffer, STATUS, and count are 0. State is IDLE.
- Bus: req at cycle t → ack and rdata at t+1. A req at t+1 is served at t+2, so back-to-back accesses run at 1 per cycle. A write takes effect at t+1.
- GO accepted at t → KICK at t+1 → RUN from t+2.
- CAPTURE happens 1 cycle after the qualifying mm_done. STATUS.done and irq are visible the cycle after CAPTURE.
- The cycle count equals the number of RUN cycles.
- A GO write and a STATUS write in the same request are impossible (separate addresses). A STATUS clear arriving in the same cycle as CAPTURE: the set wins.
- Reset mid-run: immediate return to IDLE with all registers cleared; mm_reset is high for the reset duration.

## Structure
- Shared package matmul_pkg:
  - address-map base constants (OP, GO, STATUS, COUNT, A, B, C);
  - STATUS bit positions;
  - FSM state enum;
  - op-register index constants (also used by the engine side).
- Sub-module matmul_regbank: address decode, op/A/B/C storage, read mux, bus ack.
- The FSM, counters, and irq stay in the top level.

## Test plan
- Basic 2×2 run:
  - Stimulus: op = {0,2,2,2,2}; A = [[1,2],[3,4]]; B = [[5,6],[7,8]]; GO.
  - Required: irq once; C reads 0x300=19, 0x301=22, 0x304=43, 0x305=50; STATUS=0x02.
- Dimension error: op reg1=5 with DIM=4, then GO → STATUS.err_dim=1, mm_reset never pulses, busy stays 0.
- Busy write: during RUN, write A[0][0]=99 → acked, A[0][0] keeps its old value, err_busy=1. A subsequent write of 0x08 to STATUS clears err_busy.
- Timeout: engine model holds mm_done=0 with TIMEOUT=16 → ABORT after 16 RUN cycles, err_timeout=1, C buffer unchanged, one mm_reset pulse.
- Done blanking: engine model holds mm_done=1 constantly → capture on RUN cycle 3, count=3.
- Reset mid-run: assert reset in RUN cycle 5 → next cycle all outputs are at reset values, STATUS=0, and a new GO runs normally.
